// File: rtl/mdp_pcm_sched.sv
// PCM streaming scheduler: fetches sectors into the MDP PCM ring, primes it, loops and drains.
// Optional MDP_SCHED_FADE_EN: cmd_stop during playback ramps the volume down before stopping.
module mdp_pcm_sched #(
    parameter int BLK_BYTES = 2352,
    parameter int PRIME_BLK = 2,
    parameter int LBA_W     = 24,
    parameter int FADE_DIV  = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_play,
    input  logic             cmd_stop,
    input  logic [LBA_W-1:0] cmd_lba,
    input  logic [LBA_W-1:0] cmd_len,
    input  logic             cmd_loop,
    input  logic             can_wr,
    input  logic             buf_empty,
    input  logic             wr_pulse,
    input  logic             req_ack,
    input  logic [7:0]       vol_in,
    output logic             req,
    output logic [LBA_W-1:0] req_lba,
    output logic             pcm_play,
    output logic [7:0]       vol_out,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int PW = $clog2(PRIME_BLK + 2);
    localparam logic [11:0]   BYTE_LAST = 12'(BLK_BYTES - 1);
    localparam logic [PW-1:0] PRIME_MAX = PW'(PRIME_BLK);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_REQ,
        S_XFER,
        S_DRAIN
`ifdef MDP_SCHED_FADE_EN
        , S_FADE
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [LBA_W-1:0] cur_lba_q, cur_lba_d;
    logic [LBA_W-1:0] remain_q, remain_d;
    logic [LBA_W-1:0] start_lba_q, start_lba_d;
    logic [LBA_W-1:0] start_len_q, start_len_d;
    logic [LBA_W-1:0] req_lba_q, req_lba_d;
    logic [LBA_W-1:0] remain_dec;
    logic [11:0]      byte_ctr_q, byte_ctr_d;
    logic [PW-1:0]    prime_ctr_q, prime_ctr_d;
    logic             loop_r_q, loop_r_d;
    logic             req_q, req_d;
    logic             pcm_play_q, pcm_play_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

`ifdef MDP_SCHED_FADE_EN
    localparam int DW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(FADE_DIV - 1);
    logic [7:0]    fade_vol_q, fade_vol_d;
    logic [DW-1:0] fade_div_q, fade_div_d;
`endif

    always_comb begin
        state_d     = state_q;
        cur_lba_d   = cur_lba_q;
        remain_d    = remain_q;
        start_lba_d = start_lba_q;
        start_len_d = start_len_q;
        req_lba_d   = req_lba_q;
        byte_ctr_d  = byte_ctr_q;
        prime_ctr_d = prime_ctr_q;
        loop_r_d    = loop_r_q;
        req_d       = req_q;
        pcm_play_d  = pcm_play_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        remain_dec  = remain_q - LBA_W'(1);
`ifdef MDP_SCHED_FADE_EN
        fade_vol_d  = fade_vol_q;
        fade_div_d  = fade_div_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_play && !cmd_stop) begin
                    if (cmd_len != '0) begin
                        cur_lba_d   = cmd_lba;
                        start_lba_d = cmd_lba;
                        remain_d    = cmd_len;
                        start_len_d = cmd_len;
                        loop_r_d    = cmd_loop;
                        prime_ctr_d = '0;
                        state_d     = S_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (can_wr) begin
                    req_d     = 1'b1;
                    req_lba_d = cur_lba_q;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (req_ack) begin
                    req_d      = 1'b0;
                    byte_ctr_d = '0;
                    state_d    = S_XFER;
                end
            end
            S_XFER: begin
                if (wr_pulse) begin
                    if (byte_ctr_q == BYTE_LAST) begin
                        cur_lba_d = cur_lba_q + LBA_W'(1);
                        remain_d  = remain_dec;
                        if (prime_ctr_q != PRIME_MAX)
                            prime_ctr_d = prime_ctr_q + PW'(1);
                        if (prime_ctr_d == PRIME_MAX || remain_dec == '0)
                            pcm_play_d = 1'b1;
                        // Loop restart keeps pcm_play high; priming only gates the first pass
                        if (remain_dec == '0 && loop_r_q) begin
                            cur_lba_d = start_lba_q;
                            remain_d  = start_len_q;
                            state_d   = S_WAIT;
                        end else if (remain_dec == '0) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        byte_ctr_d = byte_ctr_q + 12'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (buf_empty) begin
                    pcm_play_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end
            end
`ifdef MDP_SCHED_FADE_EN
            S_FADE: begin
                if (fade_vol_q == 8'd0) begin
                    pcm_play_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (fade_div_q == DIV_LAST) begin
                    fade_div_d = '0;
                    fade_vol_d = fade_vol_q - 8'd1;
                    if (fade_vol_q == 8'd1) begin
                        pcm_play_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end else begin
                    fade_div_d = fade_div_q + DW'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Stop overrides whatever the state logic decided this clock
        if (cmd_stop && state_q != S_IDLE) begin
`ifdef MDP_SCHED_FADE_EN
            if (state_q == S_FADE) begin
                state_d = state_q;
            end else if (pcm_play_q) begin
                req_d      = 1'b0;
                done_d     = 1'b0;
                pcm_play_d = 1'b1;
                fade_vol_d = vol_in;
                fade_div_d = '0;
                state_d    = S_FADE;
            end else begin
                req_d      = 1'b0;
                pcm_play_d = 1'b0;
                done_d     = 1'b0;
                state_d    = S_IDLE;
            end
`else
            req_d      = 1'b0;
            pcm_play_d = 1'b0;
            done_d     = 1'b0;
            state_d    = S_IDLE;
`endif
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_lba_q   <= '0;
            remain_q    <= '0;
            start_lba_q <= '0;
            start_len_q <= '0;
            req_lba_q   <= '0;
            byte_ctr_q  <= '0;
            prime_ctr_q <= '0;
            loop_r_q    <= 1'b0;
            req_q       <= 1'b0;
            pcm_play_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef MDP_SCHED_FADE_EN
            fade_vol_q  <= '0;
            fade_div_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_lba_q   <= cur_lba_d;
            remain_q    <= remain_d;
            start_lba_q <= start_lba_d;
            start_len_q <= start_len_d;
            req_lba_q   <= req_lba_d;
            byte_ctr_q  <= byte_ctr_d;
            prime_ctr_q <= prime_ctr_d;
            loop_r_q    <= loop_r_d;
            req_q       <= req_d;
            pcm_play_q  <= pcm_play_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef MDP_SCHED_FADE_EN
            fade_vol_q  <= fade_vol_d;
            fade_div_q  <= fade_div_d;
`endif
        end
    end

    // req must drop the instant rst rises, not just at the next edge
    assign req      = req_q & ~rst;
    assign req_lba  = req_lba_q;
    assign pcm_play = pcm_play_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;
`ifdef MDP_SCHED_FADE_EN
    assign vol_out  = (state_q == S_FADE) ? fade_vol_q : vol_in;
`else
    assign vol_out  = vol_in;
`endif

endmodule

// File: doc/mdp_pcm_sched.md
Name: mdp_pcm_sched

Overview:
- Sequences CD-DA style PCM streaming into the MDP PCM ring buffer.
- Accepts play/stop commands from the MDP PI register layer and issues sector fetch requests (LBA) to the MCU over a req/ack handshake.
- Counts bytes landed in the PCM buffer, primes it before enabling playback, and handles looping and end-of-track drain.
- Drives pcm_play, and the volume feeding the volume controller.

Parameters:
- BLK_BYTES, 2352, bytes per sector block written into the PCM buffer.
- PRIME_BLK, 2, blocks that must land before pcm_play rises.
- LBA_W, 24, width of sector address and length.
- FADE_DIV, 2048, clocks per volume step (fade feature only).

Ports:
- clk  in  1  system clock, all logic on negedge.
- rst  in  1  asynchronous, active-high reset.
- cmd_play  in  1  one-clock pulse: start track.
- cmd_stop  in  1  one-clock pulse: stop track.
- cmd_lba  in  LBA_W  start sector, sampled on cmd_play.
- cmd_len  in  LBA_W  sector count, sampled on cmd_play.
- cmd_loop  in  1  loop enable, sampled on cmd_play.
- can_wr  in  1  PCM buffer has room for one block.
- buf_empty  in  1  PCM buffer read side empty.
- wr_pulse  in  1  one byte written to PCM buffer (pi_we_pcm).
- req_ack  in  1  MCU accepted current fetch request.
- vol_in  in  8  volume from PI register.
- req  out  1  fetch request, held until req_ack.
- req_lba  out  LBA_W  sector being requested.
- pcm_play  out  1  PCM playback enable.
- vol_out  out  8  volume to volume controller.
- busy  out  1  state != IDLE.
- done  out  1  one-clock pulse at end of track.
- err  out  1  one-clock pulse on invalid command.

Behaviour:
- Reset values: req=0, req_lba=0, pcm_play=0, busy=0, done=0, err=0, vol_out=vol_in (combinational pass-through), state=IDLE, all counters 0.
- States: IDLE, WAIT_SPACE, REQ, XFER, DRAIN.
- Per-track registers: cur_lba, remain, loop_r, start_lba, start_len, byte_ctr (12 bit), prime_ctr.

IDLE:
- On cmd_play with cmd_len != 0: latch cmd_lba/cmd_len/cmd_loop and clear prime_ctr, then go to WAIT_SPACE.
- On cmd_play with cmd_len == 0: err=1 for one clock, stay in IDLE.

WAIT_SPACE:
- When can_wr=1, go to REQ.
- The next clock, req=1 and req_lba=cur_lba (registered).

REQ:
- Hold req and req_lba stable until req_ack=1.
- On req_ack: req=0, byte_ctr=0, go to XFER.
- req_ack is ignored outside REQ.

XFER:
- Each wr_pulse increments byte_ctr.
- When byte_ctr reaches BLK_BYTES-1 and a wr_pulse arrives (block complete):
  - cur_lba += 1, wrapping modulo 2^LBA_W.
  - remain -= 1.
  - prime_ctr saturates at PRIME_BLK.
  - pcm_play=1 once prime_ctr reaches PRIME_BLK, or once remain reaches 0 (short track).
- Block-complete routing:
  - If remain becomes 0 and loop_r=1: cur_lba=start_lba, remain=start_len, go to WAIT_SPACE.
  - If remain becomes 0 and loop_r=0: go to DRAIN.
  - Otherwise go to WAIT_SPACE.
- wr_pulse is ignored outside XFER.

DRAIN:
- When buf_empty=1: pcm_play=0, done=1 for one clock, go to IDLE.

Command rules:
- cmd_stop in any non-IDLE state: req=0, pcm_play=0, go to IDLE the next clock. No done pulse.
- In-flight bytes after a stop are ignored.
- cmd_stop and cmd_play in the same clock: stop wins, play is dropped.
- cmd_play while busy is ignored (no err).
- Loop restart keeps pcm_play=1; priming applies only to the first pass.
- Async rst mid-transfer: immediate return to reset values, with req deasserted combinationally on rst.

Optional Feature:
- Macro MDP_SCHED_FADE_EN.
- Without the macro:
  - vol_out=vol_in.
  - cmd_stop acts immediately, as above.
- With the macro:
  - Adds state FADE and an 8-bit fade_vol register.
  - cmd_stop while pcm_play=1 loads fade_vol=vol_in, drops req, and enters FADE.
  - In FADE, vol_out=fade_vol, decremented by 1 every FADE_DIV clocks.
  - When fade_vol reaches 0: pcm_play=0, go to IDLE. Duration is vol_in*FADE_DIV clocks.
  - cmd_stop while pcm_play=0 still acts immediately.
  - cmd_play is ignored in FADE.
  - In all other states, vol_out=vol_in.

Test Plan:
- Basic start: cmd_play lba=0x000100, len=3, can_wr=1.
  - req rises with req_lba=0x100.
  - After ack and 2352 wr_pulses, req_lba=0x101.
  - pcm_play rises after 2nd block.
  - DRAIN, then buf_empty=1 gives a done pulse and busy=0.
- Back-pressure: can_wr=0 after block 1 for 500 clocks.
  - req stays 0 for those 500 clocks.
  - req rises 1 clock after can_wr=1.
  - req held while req_ack is withheld 100 clocks.
- Loop with wrap: lba=0xFFFFFF, len=2, loop=1.
  - Requests 0xFFFFFF, 0x000000, 0xFFFFFF.
  - pcm_play stays 1 across the restart, no done pulse.
- Stop mid-XFER after 1000 bytes: pcm_play=0, req=0, IDLE next clock. Further wr_pulses do not change state.
- Invalid and collision commands:
  - cmd_len=0 gives an err pulse, busy=0.
  - cmd_play+cmd_stop in the same clock from IDLE: stays IDLE.
  - cmd_play while busy: ignored.
- Fade (MDP_SCHED_FADE_EN, FADE_DIV=4, vol_in=0x10):
  - cmd_stop during playback ramps vol_out 0x10→0 over 64 clocks.
  - pcm_play falls when vol_out reaches 0.
